alu_issue: RTL and testbench

Decode/issue stage that feeds the ALU: one-entry registered pipeline stage with a valid/ready handshake. Accepts a fetched RV32I instruction plus register-file read data and decodes it into ALU operands a/b and the 3-bit ALU op. Emits writeback and branch-condition controls so the execute stage can interpret the ALU zeroFlag. Sits between register-file read and the ALU.

---
 rtl/alu_issue.sv | 207 ++++++++++++++++++++
 tb/tb_alu_issue.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Decode/issue stage: registers one decoded RV32I entry for the ALU,
// with a valid/ready handshake and an issued-entry counter.
module alu_issue #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               inValid,
  output logic               inReady,
  input  logic [31:0]        instr,
  input  logic [31:0]        pc,
  input  logic [31:0]        rs1Data,
  input  logic [31:0]        rs2Data,
  output logic               outValid,
  input  logic               outReady,
  output logic [31:0]        aluA,
  output logic [31:0]        aluB,
  output logic [2:0]         aluOp,
  output logic [4:0]         rd,
  output logic               regWrite,
  output logic               isBranch,
  output logic               takeOnZero,
  output logic [31:0]        branchTarget,
  output logic               illegal,
  output logic [COUNT_W-1:0] issueCount
);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        toz;
    logic [31:0] tgt;
    logic        ill;
  } ent_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_b;
  logic [31:0] shamt_r;
  logic [31:0] shamt_i;
  logic        ok;
  logic        accept;
  logic        unused_rs1;

  ent_t               dec;
  ent_t               ent_d, ent_q;
  logic               vld_d, vld_q;
  logic [COUNT_W-1:0] cnt_d, cnt_q;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
  assign shamt_r = {27'b0, rs2Data[4:0]};
  assign shamt_i = {27'b0, instr[24:20]};

  // rs1 index is resolved by the register file before this stage
  assign unused_rs1 = ^instr[19:15];

  always_comb begin
    dec     = '0;
    ok      = 1'b0;
    dec.rd  = instr[11:7];
    dec.tgt = pc + imm_b;
    unique case (1'b1)
      opc == OPC_R: begin
        dec.a  = rs1Data;
        dec.b  = rs2Data;
        dec.rw = 1'b1;
        ok     = 1'b1;
        if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.op = OP_SUB;
        end else if (f7 != 7'b0) begin
          ok = 1'b0;
        end else begin
          case (f3)
            3'b000: dec.op = OP_ADD;
            3'b111: dec.op = OP_AND;
            3'b110: dec.op = OP_OR;
            3'b100: dec.op = OP_XOR;
            3'b011: dec.op = OP_LTU;
            3'b001: begin
              dec.op = OP_SLL;
              dec.b  = shamt_r;
            end
            3'b101: begin
              dec.op = OP_SRL;
              dec.b  = shamt_r;
            end
            default: ok = 1'b0;
          endcase
        end
      end
      opc == OPC_I: begin
        dec.a  = rs1Data;
        dec.b  = imm_i;
        dec.rw = 1'b1;
        ok     = 1'b1;
        case (f3)
          3'b000: dec.op = OP_ADD;
          3'b111: dec.op = OP_AND;
          3'b110: dec.op = OP_OR;
          3'b100: dec.op = OP_XOR;
          3'b011: dec.op = OP_LTU;
          3'b001: begin
            dec.op = OP_SLL;
            dec.b  = shamt_i;
            ok     = (f7 == 7'b0);
          end
          3'b101: begin
            dec.op = OP_SRL;
            dec.b  = shamt_i;
            ok     = (f7 == 7'b0);
          end
          default: ok = 1'b0;
        endcase
      end
      opc == OPC_B: begin
        dec.a  = rs1Data;
        dec.b  = rs2Data;
        dec.br = 1'b1;
        ok     = 1'b1;
        case (f3)
          3'b000: begin
            dec.op  = OP_SUB;
            dec.toz = 1'b1;
          end
          3'b001: dec.op = OP_SUB;
          3'b110: dec.op = OP_LTU;
          3'b111: begin
            dec.op  = OP_LTU;
            dec.toz = 1'b1;
          end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    dec.rw = dec.rw && ok && (dec.rd != 5'd0);
    // illegal entries still flow through, but as an inert ADD 0,0
    if (!ok) begin
      dec.a   = '0;
      dec.b   = '0;
      dec.op  = OP_ADD;
      dec.rw  = 1'b0;
      dec.br  = 1'b0;
      dec.toz = 1'b0;
      dec.ill = 1'b1;
    end
  end

  assign inReady = !flush && (!vld_q || outReady);
  assign accept  = inValid && inReady;

  always_comb begin
    vld_d = !flush && (accept || (vld_q && !outReady));
    ent_d = accept ? dec : ent_q;
    cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, vld_q && outReady};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign outValid     = vld_q;
  assign aluA         = ent_q.a;
  assign aluB         = ent_q.b;
  assign aluOp        = ent_q.op;
  assign rd           = ent_q.rd;
  assign regWrite     = ent_q.rw;
  assign isBranch     = ent_q.br;
  assign takeOnZero   = ent_q.toz;
  assign branchTarget = ent_q.tgt;
  assign illegal      = ent_q.ill;
  assign issueCount   = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: expected entries are queued on accept
// and compared when the stage presents them to execute.
module tb_alu_issue;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [31:0]   instr = '0;
  logic [31:0]   pc = '0;
  logic [31:0]   rs1Data = '0;
  logic [31:0]   rs2Data = '0;
  logic          outValid;
  logic          outReady = 1'b0;
  logic [31:0]   aluA;
  logic [31:0]   aluB;
  logic [2:0]    aluOp;
  logic [4:0]    rd;
  logic          regWrite;
  logic          isBranch;
  logic          takeOnZero;
  logic [31:0]   branchTarget;
  logic          illegal;
  logic [CW-1:0] issueCount;

  alu_issue #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .inValid(inValid), .inReady(inReady),
    .instr(instr), .pc(pc),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .outValid(outValid), .outReady(outReady),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .rd(rd),
    .regWrite(regWrite), .isBranch(isBranch),
    .takeOnZero(takeOnZero), .branchTarget(branchTarget),
    .illegal(illegal), .issueCount(issueCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic        br;
    logic        toz;
    logic [31:0] tgt;
    logic        ill;
  } ent_t;

  ent_t          q[$];
  int            checks = 0;
  int            failures = 0;
  logic [CW-1:0] cnt_exp = '0;

  function automatic logic [31:0] btgt(input logic [31:0] i, p);
    logic [31:0] imm;
    imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    return p + imm;
  endfunction

  function automatic ent_t mk(input logic [31:0] i, p, a, b,
                              input logic [2:0] op,
                              input logic rw, br, toz, ill);
    ent_t e;
    e.a = a; e.b = b; e.op = op; e.rd = i[11:7];
    e.rw = rw; e.br = br; e.toz = toz; e.ill = ill;
    e.tgt = btgt(i, p);
    return e;
  endfunction

  function automatic ent_t obs();
    ent_t o;
    o.a = aluA; o.b = aluB; o.op = aluOp; o.rd = rd;
    o.rw = regWrite; o.br = isBranch; o.toz = takeOnZero;
    o.tgt = branchTarget; o.ill = illegal;
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, p, a, b);
    instr = i; pc = p; rs1Data = a; rs2Data = b; inValid = 1'b1;
  endtask

  task automatic test_reset();
    ent_t got;
    step();
    got = obs();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", outValid); end
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", got); end
    checks++;
    if (issueCount !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", issueCount); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (inReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b want=1", inReady); end
  endtask

  task automatic test_rtype();
    logic [31:0] ins[9], r1[9], r2[9], bx[9];
    logic [2:0]  ops[9];
    logic        rws[9];
    logic [31:0] p;
    ent_t        e, got;
    ins = '{32'h002081B3, 32'h402081B3, 32'h002091B3, 32'h0020D1B3, 32'h0020B1B3,
            32'h0020F1B3, 32'h0020E1B3, 32'h0020C1B3, 32'h00208033};
    r1  = '{32'd5, 32'd5, 32'h0000F00F, 32'h80000000, 32'd1,
            32'hF0F0F0F0, 32'h12345678, 32'h12345678, 32'd3};
    r2  = '{32'd7, 32'd7, 32'h23, 32'hFFFFFFE4, 32'hFFFFFFFF,
            32'h0FF00FF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'd4};
    bx  = '{32'd7, 32'd7, 32'd3, 32'd4, 32'hFFFFFFFF,
            32'h0FF00FF0, 32'h9ABCDEF0, 32'h9ABCDEF0, 32'd4};
    ops = '{3'd0, 3'd1, 3'd5, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4, 3'd0};
    rws = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    p = 32'h0000_1000;
    outReady = 1'b1;
    for (int k = 0; k < 9; k++) begin
      drive(ins[k], p, r1[k], r2[k]);
      q.push_back(mk(ins[k], p, r1[k], bx[k], ops[k], rws[k], 1'b0, 1'b0, 1'b0));
      checks++;
      if (inReady !== 1'b1) begin failures++; $display("FAIL rtype_inready[%0d] got=%b want=1", k, inReady); end
      step();
      checks++;
      if (outValid !== 1'b1) begin failures++; $display("FAIL rtype_valid[%0d] got=%b want=1", k, outValid); end
      e = q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin failures++; $display("FAIL rtype[%0d] got=%h want=%h", k, got, e); end
      cnt_exp++;
    end
    inValid = 1'b0;
    step();
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL rtype_count got=%0d want=%0d", issueCount, cnt_exp); end
  endtask

  task automatic test_itype();
    logic [31:0] ins[8], r1[8], bx[8];
    logic [2:0]  ops[8];
    logic        rws[8];
    logic [31:0] p;
    ent_t        e, got;
    ins = '{32'h01F29293, 32'hFFF08093, 32'h0012D293, 32'hFFF0B093,
            32'h0F00F093, 32'h0F00E093, 32'h0F00C093, 32'h00000013};
    r1  = '{32'h80000001, 32'd10, 32'hF0000000, 32'd7,
            32'h0000FFFF, 32'd1, 32'd2, 32'd0};
    bx  = '{32'd31, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF,
            32'hF0, 32'hF0, 32'hF0, 32'd0};
    ops = '{3'd5, 3'd0, 3'd6, 3'd7, 3'd2, 3'd3, 3'd4, 3'd0};
    rws = '{1, 1, 1, 1, 1, 1, 1, 0};
    p = 32'h0000_2000;
    outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(ins[k], p, r1[k], 32'hDEADBEEF);
      q.push_back(mk(ins[k], p, r1[k], bx[k], ops[k], rws[k], 1'b0, 1'b0, 1'b0));
      step();
      checks++;
      if (outValid !== 1'b1) begin failures++; $display("FAIL itype_valid[%0d] got=%b want=1", k, outValid); end
      e = q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin failures++; $display("FAIL itype[%0d] got=%h want=%h", k, got, e); end
      cnt_exp++;
    end
    inValid = 1'b0;
    step();
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL itype_count got=%0d want=%0d", issueCount, cnt_exp); end
  endtask

  task automatic test_branch();
    logic [31:0] ins[4], pcs[4], tg[4];
    logic [2:0]  ops[4];
    logic        tz[4];
    ent_t        e, got;
    ins = '{32'hFE209CE3, 32'hFE20FCE3, 32'h00208863, 32'hFE20ECE3};
    pcs = '{32'h100, 32'h100, 32'hFFFFFFF0, 32'h200};
    tg  = '{32'hF8, 32'hF8, 32'h0, 32'h1F8};
    ops = '{3'd1, 3'd7, 3'd1, 3'd7};
    tz  = '{0, 1, 1, 0};
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(ins[k], pcs[k], 32'h0000_0011 + 32'(k), 32'h0000_0100);
      e = mk(ins[k], pcs[k], 32'h0000_0011 + 32'(k), 32'h0000_0100,
             ops[k], 1'b0, 1'b1, tz[k], 1'b0);
      e.tgt = tg[k];
      q.push_back(e);
      step();
      checks++;
      if (outValid !== 1'b1) begin failures++; $display("FAIL branch_valid[%0d] got=%b want=1", k, outValid); end
      e = q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin failures++; $display("FAIL branch[%0d] got=%h want=%h", k, got, e); end
      cnt_exp++;
    end
    inValid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ins[7];
    logic [31:0] p;
    ent_t        e, got;
    ins = '{32'h4020D1B3, 32'h123452B7, 32'h0020A1B3, 32'h022081B3,
            32'hFE20CCE3, 32'h4012D293, 32'hFFF0A093};
    p = 32'h0000_0040;
    outReady = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive(ins[k], p, 32'h11111111, 32'h22222222);
      q.push_back(mk(ins[k], p, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      step();
      checks++;
      if (outValid !== 1'b1) begin failures++; $display("FAIL illegal_valid[%0d] got=%b want=1", k, outValid); end
      e = q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin failures++; $display("FAIL illegal[%0d] got=%h want=%h", k, got, e); end
      cnt_exp++;
    end
    inValid = 1'b0;
    step();
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL illegal_count got=%0d want=%0d", issueCount, cnt_exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins[4];
    logic        rdy[4];
    ent_t        ex[4];
    ent_t        e, got;
    int          idx, pops, stalls, stall_cyc;
    logic        done;
    ins = '{32'h002081B3, 32'h402081B3, 32'h0F00F093, 32'h00208863};
    rdy = '{1, 0, 1, 1};
    ex[0] = mk(ins[0], 32'h300, 32'd9, 32'd4, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[1] = mk(ins[1], 32'h300, 32'd9, 32'd4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[2] = mk(ins[2], 32'h300, 32'd9, 32'hF0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[3] = mk(ins[3], 32'h300, 32'd9, 32'd4, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    idx = 0; pops = 0; stalls = 0; stall_cyc = -1; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      outReady = (cyc < 4) ? rdy[cyc] : 1'b1;
      if (idx < 4) drive(ins[idx], 32'h300, 32'd9, 32'd4);
      else inValid = 1'b0;
      #1;
      if (!inReady) begin stalls++; stall_cyc = cyc; end
      if (outValid && outReady) begin
        checks++;
        if (q.size() == 0) begin
          failures++; $display("FAIL b2b_dup got=extra want=none cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          got = obs();
          if (got !== e) begin failures++; $display("FAIL b2b[%0d] got=%h want=%h", pops, got, e); end
          pops++;
          cnt_exp++;
        end
      end
      if (inValid && inReady) begin q.push_back(ex[idx]); idx++; end
      step();
      done = (idx == 4) && (q.size() == 0);
    end
    inValid = 1'b0;
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_timeout got=%0d want=4 issued", pops); end
    checks++;
    if (pops !== 4) begin failures++; $display("FAIL b2b_pops got=%0d want=4", pops); end
    checks++;
    if (stalls !== 1 || stall_cyc !== 1) begin failures++; $display("FAIL b2b_stall got=%0d@%0d want=1@1", stalls, stall_cyc); end
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", outValid); end
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL b2b_count got=%0d want=%0d", issueCount, cnt_exp); end
  endtask

  task automatic test_flush();
    ent_t e, got;
    outReady = 1'b0;
    drive(32'h002081B3, 32'h400, 32'd1, 32'd2);
    q.push_back(mk(32'h002081B3, 32'h400, 32'd1, 32'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    inValid = 1'b0;
    e = q[0];
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (inReady !== 1'b0) begin failures++; $display("FAIL hold_inready[%0d] got=%b want=0", k, inReady); end
      step();
      got = obs();
      checks++;
      if (outValid !== 1'b1 || got !== e) begin failures++; $display("FAIL hold[%0d] got=%b/%h want=1/%h", k, outValid, got, e); end
    end
    flush = 1'b1;
    drive(32'h402081B3, 32'h404, 32'd3, 32'd4);
    #1;
    checks++;
    if (inReady !== 1'b0) begin failures++; $display("FAIL flush_inready got=%b want=0", inReady); end
    step();
    flush = 1'b0;
    inValid = 1'b0;
    void'(q.pop_front());
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b want=0", outValid); end
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL flush_count got=%0d want=%0d", issueCount, cnt_exp); end
    drive(32'h0020F1B3, 32'h408, 32'd5, 32'd6);
    q.push_back(mk(32'h0020F1B3, 32'h408, 32'd5, 32'd6, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    step();
    inValid = 1'b0;
    flush = 1'b1;
    outReady = 1'b1;
    e = q.pop_front();
    got = obs();
    checks++;
    if (got !== e) begin failures++; $display("FAIL flush_done got=%h want=%h", got, e); end
    cnt_exp++;
    step();
    flush = 1'b0;
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL flush2_valid got=%b want=0", outValid); end
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL flush2_count got=%0d want=%0d", issueCount, cnt_exp); end
    step();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL flush_ghost got=%b want=0", outValid); end
  endtask

  task automatic test_count_wrap();
    logic [CW-1:0] base, want;
    ent_t          e, got;
    base = cnt_exp;
    outReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(32'h00108093, 32'h500, 32'(i), 32'd0);
      q.push_back(mk(32'h00108093, 32'h500, 32'(i), 32'd1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      step();
      want = base + i[CW-1:0];
      checks++;
      if (issueCount !== want) begin failures++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", i, issueCount, want); end
      e = q.pop_front();
      got = obs();
      checks++;
      if (got !== e) begin failures++; $display("FAIL wrap_entry[%0d] got=%h want=%h", i, got, e); end
    end
    inValid = 1'b0;
    step();
    cnt_exp = base + CW'(17);
    checks++;
    if (issueCount !== cnt_exp) begin failures++; $display("FAIL wrap_final got=%0d want=%0d", issueCount, cnt_exp); end
  endtask

  task automatic test_reset_hold();
    ent_t got;
    outReady = 1'b0;
    drive(32'h002081B3, 32'h600, 32'd5, 32'd7);
    step();
    inValid = 1'b0;
    checks++;
    if (outValid !== 1'b1) begin failures++; $display("FAIL rsthold_setup got=%b want=1", outValid); end
    #2;
    rst_n = 1'b0;
    #1;
    got = obs();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL rsthold_valid got=%b want=0", outValid); end
    checks++;
    if (got !== '0) begin failures++; $display("FAIL rsthold_outputs got=%h want=0", got); end
    checks++;
    if (issueCount !== '0) begin failures++; $display("FAIL rsthold_count got=%0d want=0", issueCount); end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    cnt_exp = '0;
    step();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL rsthold_after got=%b want=0", outValid); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_count_wrap();
    test_reset_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
